arith_ops_unit: RTL and testbench



---
 rtl/arith_ops_unit.sv | 116 +++++++++++
 tb/tb_arith_ops_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arith_ops_unit.sv
// arith_ops_unit: 4-bit arithmetic unit with a registered 8-bit result.
//   Opcodes owned here (shared 4-bit ALU opcode space):
//     0110 ADD  sign-extended two's-complement sum, v = signed overflow
//     0111 SUB  sign-extended two's-complement difference, v = signed overflow
//     1000 MUL  unsigned 4x4 -> 8-bit product, v = 0
//     1001 DIV  unsigned divide, Y = {remainder, quotient}, v = divide-by-zero
//   Any other opcode holds Y/v unchanged.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears Y and v
//   OP_code  operation select
//   A, B     operands (minuend/dividend, subtrahend/divisor)
//   Y        registered 8-bit result
//   v        registered overflow / error flag
module arith_ops_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] OP_code,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] Y,
  output logic       v
);

  localparam logic [3:0] OpAdd = 4'b0110;
  localparam logic [3:0] OpSub = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1000;
  localparam logic [3:0] OpDiv = 4'b1001;

  logic [7:0] y_d, y_q;
  logic       v_d, v_q;

  // Add/subtract slice: subtraction is A + ~B + 1 through the same adder.
  logic       sub_sel;
  logic [3:0] b_eff;
  logic [3:0] as_sum;
  logic       as_ovf;

  always_comb begin
    sub_sel = (OP_code == OpSub);
    b_eff   = sub_sel ? ~B : B;
    as_sum  = A + b_eff + {3'b000, sub_sel};
    // Overflow when both adder inputs share a sign the result does not.
    as_ovf  = (A[3] == b_eff[3]) && (as_sum[3] != A[3]);
  end

  // Array multiplier: accumulate shifted partial products row by row.
  logic [7:0] mul_prod;

  always_comb begin
    mul_prod = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (B[i]) begin
        mul_prod = mul_prod + ({4'h0, A} << i);
      end
    end
  end

  // Restoring divider: shift in one dividend bit per row, subtract the
  // divisor when it fits. The remainder never exceeds 4 bits, but the
  // partial remainder needs a fifth bit before the compare.
  logic [3:0] div_quo;
  logic [4:0] div_rem;

  always_comb begin
    div_quo = 4'h0;
    div_rem = 5'h00;
    for (int i = 3; i >= 0; i--) begin
      div_rem = {div_rem[3:0], A[i]};
      if (div_rem >= {1'b0, B}) begin
        div_rem    = div_rem - {1'b0, B};
        div_quo[i] = 1'b1;
      end
    end
  end

  // Result select; unowned opcodes hold the previous capture.
  always_comb begin
    y_d = y_q;
    v_d = v_q;
    case (OP_code)
      OpAdd, OpSub: begin
        y_d = {{4{as_sum[3]}}, as_sum};
        v_d = as_ovf;
      end
      OpMul: begin
        y_d = mul_prod;
        v_d = 1'b0;
      end
      OpDiv: begin
        if (B == 4'h0) begin
          y_d = {A, 4'hF};
          v_d = 1'b1;
        end else begin
          y_d = {div_rem[3:0], div_quo};
          v_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 8'h00;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign Y = y_q;
  assign v = v_q;

endmodule

// File: tb/tb_arith_ops_unit.sv
module tb_arith_ops_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] OP_code;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] Y;
  logic       v;

  int checks = 0;
  int errors = 0;

  // Reference state: what Y/v should currently show.
  logic [7:0] exp_y;
  logic       exp_v;

  arith_ops_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .OP_code(OP_code),
    .A      (A),
    .B      (B),
    .Y      (Y),
    .v      (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y;
    logic       v;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [7:0] sext4(input int val);
    int s;
    s = val & 15;
    return (s >= 8) ? 8'(s + 240) : 8'(s);
  endfunction

  function automatic int to_signed(input logic [3:0] x);
    return (int'(x) >= 8) ? int'(x) - 16 : int'(x);
  endfunction

  // Behavioural model from the arithmetic definition of each opcode.
  task automatic model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       inout logic [7:0] y, inout logic vf);
    int r;
    case (op)
      4'b0110: begin
        r  = to_signed(a) + to_signed(b);
        y  = sext4(r);
        vf = (r > 7) || (r < -8);
      end
      4'b0111: begin
        r  = to_signed(a) - to_signed(b);
        y  = sext4(r);
        vf = (r > 7) || (r < -8);
      end
      4'b1000: begin
        y  = 8'(int'(a) * int'(b));
        vf = 1'b0;
      end
      4'b1001: begin
        if (b == 0) begin
          y  = {a, 4'hF};
          vf = 1'b1;
        end else begin
          y  = 8'((int'(a) % int'(b)) * 16 + int'(a) / int'(b));
          vf = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [7:0] ey, input logic ev);
    checks++;
    if (Y !== ey || v !== ev) begin
      errors++;
      $display("FAIL %s: got Y=%02h v=%0b, expected Y=%02h v=%0b (op=%04b A=%0h B=%0h)",
               name, Y, v, ey, ev, OP_code, A, B);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge capture,
  // then sample at the next falling edge (just before the following capture).
  task automatic step(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    OP_code = op;
    A       = a;
    B       = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_model(input string name, input logic [3:0] op, input logic [3:0] a,
                            input logic [3:0] b);
    model(op, a, b, exp_y, exp_v);
    step(op, a, b);
    check(name, exp_y, exp_v);
  endtask

  initial begin
    vecs[0]  = '{"add_7p1",  4'b0110, 4'h7, 4'h1, 8'hF8, 1'b1};
    vecs[1]  = '{"add_8p8",  4'b0110, 4'h8, 4'h8, 8'h00, 1'b1};
    vecs[2]  = '{"add_Fp1",  4'b0110, 4'hF, 4'h1, 8'h00, 1'b0};
    vecs[3]  = '{"sub_8m1",  4'b0111, 4'h8, 4'h1, 8'h07, 1'b1};
    vecs[4]  = '{"sub_2m5",  4'b0111, 4'h2, 4'h5, 8'hFD, 1'b0};
    vecs[5]  = '{"sub_7mF",  4'b0111, 4'h7, 4'hF, 8'hF8, 1'b1};
    vecs[6]  = '{"mul_FxF",  4'b1000, 4'hF, 4'hF, 8'hE1, 1'b0};
    vecs[7]  = '{"mul_0x9",  4'b1000, 4'h0, 4'h9, 8'h00, 1'b0};
    vecs[8]  = '{"mul_6x7",  4'b1000, 4'h6, 4'h7, 8'h2A, 1'b0};
    vecs[9]  = '{"div_D_4",  4'b1001, 4'hD, 4'h4, 8'h13, 1'b0};
    vecs[10] = '{"div_F_1",  4'b1001, 4'hF, 4'h1, 8'h0F, 1'b0};
    vecs[11] = '{"div_3_7",  4'b1001, 4'h3, 4'h7, 8'h30, 1'b0};
    vecs[12] = '{"div_9_0",  4'b1001, 4'h9, 4'h0, 8'h9F, 1'b1};
    vecs[13] = '{"add_3p4",  4'b0110, 4'h3, 4'h4, 8'h07, 1'b0};

    rst_n   = 1'b0;
    OP_code = 4'b0000;
    A       = 4'h0;
    B       = 4'h0;
    exp_y   = 8'h00;
    exp_v   = 1'b0;

    // Reset holds through clock edges.
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 8'h00, 1'b0);

    // Release with ADD 3+4.
    rst_n = 1'b1;
    step(4'b0110, 4'h3, 4'h4);
    check("reset_release_add", 8'h07, 1'b0);

    // Mid-stream reset clears without a clock edge.
    step(4'b1000, 4'hF, 4'hF);
    check("pre_reset_mul", 8'hE1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Corner-case table.
    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].y, vecs[i].v);
    end

    // Hold on unowned opcode, then zero-bubble switch.
    step(4'b0110, 4'h7, 4'h1);
    check("hold_setup", 8'hF8, 1'b1);
    step(4'b0000, 4'h2, 4'h2);
    check("hold_op0", 8'hF8, 1'b1);
    step(4'b1000, 4'h2, 4'h2);
    check("switch_mul", 8'h04, 1'b0);
    exp_y = 8'h04;
    exp_v = 1'b0;

    // Exhaustive sweep of each owned opcode.
    for (int op = 6; op <= 9; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          step_model("exhaustive", 4'(op), 4'(a), 4'(b));
        end
      end
    end

    // Random opcodes (including unowned ones) and operands.
    for (int n = 0; n < 400; n++) begin
      step_model("random", 4'($urandom_range(15, 0)), 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
